// File: rtl/dsp_adc_reader.sv
// Serial 12-bit ADC reader: SPI-style frame capture, mid-scale magnitude, windowed peak (or mean
// when DSP_AVG_EN is defined) presented as an 8-bit volume byte with a one-cycle ready strobe.
module dsp_adc_reader #(
  parameter int CLK_DIV  = 4,
  parameter int CONV_GAP = 8,
  parameter int WINDOW   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] dsp_data,
  output logic       dsp_ready
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(CONV_GAP + 1);
  localparam int CW = $clog2(WINDOW);
  localparam int LW = $clog2(WINDOW);
  localparam int AW = 8 + LW;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] count_q, count_d;
  logic [11:0]   shift_q, shift_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
`ifdef DSP_AVG_EN
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_sum;
`else
  logic [7:0]    peak_q, peak_d;
  logic [7:0]    peak_max;
`endif

  logic [7:0] mag8;
  logic       div_last;
  logic       gap_done;
  logic       win_last;

  // Only the last 12 captured bits survive in the shifter, so the 4 leading bits drop out.
  // For s < 2048, 2047 - s is the bitwise inverse of s[10:0]; truncation keeps bits 10..3.
  assign mag8     = shift_q[11] ? shift_q[10:3] : ~shift_q[10:3];
  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign gap_done = (gap_q >= GW'(CONV_GAP - 1));
  assign win_last = (count_q == CW'(WINDOW - 1));

`ifdef DSP_AVG_EN
  assign acc_sum  = acc_q + AW'(mag8);
`else
  assign peak_max = (mag8 > peak_q) ? mag8 : peak_q;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    count_d = count_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
`ifdef DSP_AVG_EN
    acc_d   = acc_q;
`else
    peak_d  = peak_q;
`endif
    case (state_q)
      IDLE: begin
        if (!gap_done) gap_d = gap_q + 1'b1;
        if (!enable) begin
          count_d = '0;
`ifdef DSP_AVG_EN
          acc_d   = '0;
`else
          peak_d  = '0;
`endif
        end else if (gap_done) begin
          state_d = SETUP;
          div_d   = '0;
        end
      end
      SETUP: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          // End of a low half: this edge raises sclk, so the data bit is taken now.
          if (!half_q[0]) shift_d = {shift_q[10:0], adc_miso};
          if (half_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gap_d   = '0;
        count_d = count_q + 1'b1;
`ifdef DSP_AVG_EN
        acc_d   = acc_sum;
`else
        peak_d  = peak_max;
`endif
        if (win_last) begin
`ifdef DSP_AVG_EN
          data_d = 8'(acc_sum >> LW);
          acc_d  = '0;
`else
          data_d = peak_max;
          peak_d = '0;
`endif
          count_d = '0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Pin levels are registered from the next state so they line up with state_q glitch-free.
    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d = (state_d == SHIFT) && half_d[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      count_q <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
`ifdef DSP_AVG_EN
      acc_q   <= '0;
`else
      peak_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      ready_q <= ready_d;
`ifdef DSP_AVG_EN
      acc_q   <= acc_d;
`else
      peak_q  <= peak_d;
`endif
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign dsp_data  = data_q;
  assign dsp_ready = ready_q;

endmodule

// File: tb/tb_dsp_adc_reader.sv
// Self-checking bench for dsp_adc_reader: behavioural ADC model, expected-window queue,
// frame timing, window clearing, enable drop and asynchronous reset mid-frame.
module tb_dsp_adc_reader;

  localparam int CLK_DIV  = 4;
  localparam int CONV_GAP = 8;
  localparam int WINDOW   = 4;
  localparam int PERIOD   = CONV_GAP + CLK_DIV + 32 * CLK_DIV + 1;
  localparam int CS_LOW   = CLK_DIV + 32 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       adc_miso;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] dsp_data;
  logic       dsp_ready;

  int tests_run = 0;
  int fails     = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dsp_adc_reader #(.CLK_DIV(CLK_DIV), .CONV_GAP(CONV_GAP), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .dsp_data(dsp_data), .dsp_ready(dsp_ready)
  );

  // ADC model: one sample per frame from samp_mem, MSB first, next bit after each sclk fall.
  logic [11:0] samp_mem [256];
  logic [7:0]  frame_idx = '0;
  logic [15:0] frame_w   = '0;
  logic [3:0]  bit_idx   = 4'd15;
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      frame_w   = {4'h0, samp_mem[frame_idx]};
      frame_idx = frame_idx + 8'd1;
      bit_idx   = 4'd15;
    end else if (!adc_cs_n && prev_sclk && !adc_sclk && bit_idx != 4'd0) begin
      bit_idx = bit_idx - 4'd1;
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  assign adc_miso = frame_w[bit_idx];

  function automatic logic [7:0] mag8_of(input logic [11:0] s);
    int m;
    if (int'(s) >= 2048) m = int'(s) - 2048;
    else m = 2047 - int'(s);
    return 8'(m / 8);
  endfunction

  // Queue the next WINDOW samples starting at the next frame and push the expected result.
  task automatic load_window(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3);
    logic [11:0] s [4];
    int acc;
    int pk;
    int m;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    acc = 0;
    pk  = 0;
    for (int i = 0; i < 4; i++) begin
      samp_mem[(int'(frame_idx) + i) % 256] = s[i];
      m = int'(mag8_of(s[i]));
      acc += m;
      if (m > pk) pk = m;
    end
`ifdef DSP_AVG_EN
    exp_q.push_back(8'(acc / WINDOW));
`else
    exp_q.push_back(8'(pk));
`endif
  endtask

  // Waits for a strobe; reports data at the strobe, a repeated strobe, and data changes between strobes.
  task automatic wait_ready(input int budget, output bit got, output logic [7:0] data,
                            output bit dbl, output bit unstable);
    logic [7:0] held;
    int n;
    got = 1'b0; dbl = 1'b0; unstable = 1'b0; data = '0; n = 0;
    held = dsp_data;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (dsp_ready) begin
        got  = 1'b1;
        data = dsp_data;
      end else if (dsp_data !== held) begin
        unstable = 1'b1;
      end
    end
    if (got) begin
      @(negedge clk);
      if (dsp_ready !== 1'b0) dbl = 1'b1;
      if (dsp_data !== data) unstable = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (adc_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    tests_run++;
    if (adc_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    tests_run++;
    if (dsp_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", dsp_data); end
    tests_run++;
    if (dsp_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", dsp_ready); end
    reset = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_frame_timing();
    int n, low_len, rises, bad_runs, run, gap, low2, cyc;
    logic prev, first_low;
    time t_en;
    bit got, dbl, unstable;
    logic [7:0] data, exp;
    load_window(12'h800, 12'h900, 12'h7FF, 12'h800);
    enable = 1'b1;
    t_en = $time;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 300) begin @(negedge clk); n++; end
    low_len = 0; rises = 0; bad_runs = 0; run = 0; prev = 1'b0; first_low = 1'b1;
    while (adc_cs_n === 1'b0 && low_len < 300) begin
      if (adc_sclk !== prev) begin
        if (prev) begin
          if (run != CLK_DIV) bad_runs++;
        end else begin
          if (run != (first_low ? 2 * CLK_DIV : CLK_DIV)) bad_runs++;
          first_low = 1'b0;
          rises++;
        end
        run  = 0;
        prev = adc_sclk;
      end
      run++;
      low_len++;
      @(negedge clk);
    end
    if (!prev || run != CLK_DIV) bad_runs++;
    tests_run++;
    if (low_len != CS_LOW) begin fails++; $display("FAIL cs_low_len: got %0d expected %0d", low_len, CS_LOW); end
    tests_run++;
    if (rises != 16) begin fails++; $display("FAIL sclk_pulses: got %0d expected 16", rises); end
    tests_run++;
    if (bad_runs != 0) begin fails++; $display("FAIL sclk_phase_len: got %0d bad phases expected 0", bad_runs); end
    gap = 0;
    while (adc_cs_n === 1'b1 && gap < 300) begin @(negedge clk); gap++; end
    low2 = 0;
    while (adc_cs_n === 1'b0 && low2 < 300) begin @(negedge clk); low2++; end
    tests_run++;
    if (gap != CONV_GAP + 1) begin fails++; $display("FAIL cs_high_gap: got %0d expected %0d", gap, CONV_GAP + 1); end
    tests_run++;
    if (gap + low2 != PERIOD) begin fails++; $display("FAIL frame_period: got %0d expected %0d", gap + low2, PERIOD); end
    wait_ready(3 * PERIOD, got, data, dbl, unstable);
    cyc = int'(($time - t_en) / 10);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (!got) begin fails++; $display("FAIL first_strobe: got none expected one"); end
    tests_run++;
    if (data !== exp) begin fails++; $display("FAIL first_window_data: got %h expected %h", data, exp); end
    tests_run++;
    if (cyc <= 3 * PERIOD || cyc > 4 * PERIOD + 2) begin
      fails++; $display("FAIL first_strobe_time: got %0d cycles expected %0d..%0d", cyc, 3 * PERIOD + 1, 4 * PERIOD + 2);
    end
    tests_run++;
    if (dbl || unstable) begin fails++; $display("FAIL first_strobe_shape: got dbl=%0b unstable=%0b expected 0 0", dbl, unstable); end
  endtask

  task automatic test_peak_clear();
    bit got, dbl, unstable;
    logic [7:0] data, exp;
    for (int w = 0; w < 3; w++) begin
      case (w)
        0: load_window(12'h000, 12'h800, 12'h800, 12'h800);
        1: load_window(12'hFFF, 12'h800, 12'h800, 12'h800);
        default: load_window(12'h800, 12'h800, 12'h800, 12'h800);
      endcase
      wait_ready(WINDOW * PERIOD + 20, got, data, dbl, unstable);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests_run++;
      if (!got || data !== exp || dbl || unstable) begin
        fails++;
        $display("FAIL window_%0d: got strobe=%0b data=%h dbl=%0b unstable=%0b expected strobe=1 data=%h",
                 w, got, data, dbl, unstable, exp);
      end
    end
  endtask

  task automatic test_enable_drop();
    int n, falls, low_len, idle_falls, strobes;
    logic pcs;
    logic [7:0] base, data, exp;
    bit got, dbl, unstable;
    base = frame_idx;
    samp_mem[base] = 12'hFFF;
    samp_mem[8'(base + 8'd1)] = 12'hFFF;
    falls = 0; n = 0; pcs = adc_cs_n;
    while (falls < 2 && n < 2 * PERIOD + 50) begin
      @(negedge clk); n++;
      if (pcs && !adc_cs_n) falls++;
      pcs = adc_cs_n;
    end
    low_len = 0;
    while (adc_cs_n === 1'b0 && low_len < 300) begin
      low_len++;
      if (low_len == 20) enable = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (low_len != CS_LOW) begin fails++; $display("FAIL drop_frame_len: got %0d expected %0d", low_len, CS_LOW); end
    idle_falls = 0; strobes = 0; pcs = adc_cs_n;
    repeat (5 * PERIOD) begin
      @(negedge clk);
      if (pcs && !adc_cs_n) idle_falls++;
      if (dsp_ready) strobes++;
      pcs = adc_cs_n;
    end
    tests_run++;
    if (idle_falls != 0) begin fails++; $display("FAIL drop_no_frames: got %0d frames expected 0", idle_falls); end
    tests_run++;
    if (strobes != 0) begin fails++; $display("FAIL drop_no_strobe: got %0d strobes expected 0", strobes); end
    base = frame_idx;
    load_window(12'h900, 12'h7FF, 12'h800, 12'hA00);
    enable = 1'b1;
    wait_ready(WINDOW * PERIOD + 40, got, data, dbl, unstable);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (!got || data !== exp) begin fails++; $display("FAIL reenable_data: got strobe=%0b data=%h expected strobe=1 data=%h", got, data, exp); end
    tests_run++;
    if (8'(frame_idx - base) != 8'(WINDOW)) begin
      fails++; $display("FAIL reenable_frames: got %0d expected %0d", 8'(frame_idx - base), WINDOW);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, rises;
    logic prev;
    logic [7:0] base, data, exp;
    bit got, dbl, unstable;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 300) begin @(negedge clk); n++; end
    rises = 0; prev = adc_sclk; n = 0;
    while (rises < 7 && n < 300) begin
      @(negedge clk); n++;
      if (adc_sclk && !prev) rises++;
      prev = adc_sclk;
    end
    tests_run++;
    if (rises != 7 || adc_sclk !== 1'b1) begin fails++; $display("FAIL mid_frame_reach: got rises=%0d sclk=%b expected 7 1", rises, adc_sclk); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0) begin
      fails++; $display("FAIL async_reset_pins: got cs_n=%b sclk=%b expected 1 0", adc_cs_n, adc_sclk);
    end
    tests_run++;
    if (dsp_data !== 8'h00 || dsp_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset_out: got data=%h ready=%b expected 00 0", dsp_data, dsp_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = frame_idx;
    load_window(12'h123, 12'hE00, 12'h800, 12'h6F0);
    wait_ready((WINDOW + 1) * PERIOD, got, data, dbl, unstable);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (!got || data !== exp) begin fails++; $display("FAIL post_reset_data: got strobe=%0b data=%h expected strobe=1 data=%h", got, data, exp); end
    tests_run++;
    if (8'(frame_idx - base) != 8'(WINDOW)) begin
      fails++; $display("FAIL post_reset_frames: got %0d expected %0d", 8'(frame_idx - base), WINDOW);
    end
  endtask

  task automatic test_random_windows();
    bit got, dbl, unstable;
    logic [7:0] data, exp;
    for (int w = 0; w < 3; w++) begin
      load_window(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      wait_ready(WINDOW * PERIOD + 20, got, data, dbl, unstable);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests_run++;
      if (!got || data !== exp || dbl || unstable) begin
        fails++;
        $display("FAIL random_window_%0d: got strobe=%0b data=%h dbl=%0b unstable=%0b expected strobe=1 data=%h",
                 w, got, data, dbl, unstable, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) samp_mem[i] = 12'h800;
    reset  = 1'b1;
    enable = 1'b0;
    test_reset();
    test_frame_timing();
    test_peak_clear();
    test_enable_drop();
    test_reset_mid_frame();
    test_random_windows();
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL leftover_expected: got %0d queued expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
